// File: rtl/pc_fetch.sv
// Program counter and fetch stage for the picoMIPS core: drives program memory, registers the IR.
// Optional build macro PC_OVF_TRAP_EN: halt instead of wrapping when sequential fetch passes the top word.
module pc_fetch #(
  parameter int Psize = 6,
  parameter int Isize = 17,
  parameter int Csize = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             abs_branch,
  input  logic             rel_branch,
  input  logic [Psize-1:0] branch_addr,
  input  logic [Psize-1:0] rel_offset,
  input  logic [Isize-1:0] instr,
  output logic [Psize-1:0] address,
  output logic [Isize-1:0] ir,
  output logic [Psize-1:0] ir_pc,
  output logic             ir_valid,
  output logic             halted,
  output logic [Csize-1:0] fetch_count
);

  logic             take;
  logic [Psize-1:0] target;
  logic [Csize-1:0] count_inc;

  // Bubbles never branch; absolute wins when both branch kinds are decoded.
  always_comb begin
    take      = ir_valid & (abs_branch | rel_branch);
    target    = abs_branch ? branch_addr : ir_pc + rel_offset;
    count_inc = (&fetch_count) ? fetch_count : fetch_count + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address     <= '0;
      ir          <= '0;
      ir_pc       <= '0;
      ir_valid    <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else if (!halted && !stall) begin
      if (take) begin
        // Flush the wrong-path instruction; branch-to-self parks the core.
        address  <= target;
        ir       <= '0;
        ir_valid <= 1'b0;
        if (target == ir_pc)
          halted <= 1'b1;
      end else begin
        ir          <= instr;
        ir_pc       <= address;
        ir_valid    <= 1'b1;
        fetch_count <= count_inc;
`ifdef PC_OVF_TRAP_EN
        if (&address)
          halted <= 1'b1;
        else
          address <= address + 1'b1;
`else
        address <= address + 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: directed stimulus pushes hand-computed post-edge state,
// a negedge monitor pops and compares it.
module tb_pc_fetch;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        abs_branch;
  logic        rel_branch;
  logic [5:0]  branch_addr;
  logic [5:0]  rel_offset;
  logic [16:0] instr;
  logic [5:0]  address;
  logic [16:0] ir;
  logic [5:0]  ir_pc;
  logic        ir_valid;
  logic        halted;
  logic [15:0] fetch_count;

  typedef struct {
    logic [5:0]  addr;
    logic [16:0] ir;
    logic [5:0]  pc;
    logic        v;
    logic        h;
    logic [15:0] fc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  pc_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .abs_branch(abs_branch),
    .rel_branch(rel_branch), .branch_addr(branch_addr), .rel_offset(rel_offset),
    .instr(instr), .address(address), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid),
    .halted(halted), .fetch_count(fetch_count)
  );

  // Program memory model: mem[i] = i, combinational read.
  assign instr = {11'b0, address};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string tag, input exp_t e);
    chk({tag, ".address"},     32'(address),     32'(e.addr));
    chk({tag, ".ir"},          32'(ir),          32'(e.ir));
    chk({tag, ".ir_pc"},       32'(ir_pc),       32'(e.pc));
    chk({tag, ".ir_valid"},    32'(ir_valid),    32'(e.v));
    chk({tag, ".halted"},      32'(halted),      32'(e.h));
    chk({tag, ".fetch_count"}, 32'(fetch_count), 32'(e.fc));
  endtask

  function automatic exp_t mk(input logic [5:0] a, input logic [16:0] i, input logic [5:0] p,
                              input logic v, input logic h, input logic [15:0] f);
    exp_t e;
    e.addr = a; e.ir = i; e.pc = p; e.v = v; e.h = h; e.fc = f;
    return e;
  endfunction

  // Drive inputs for the next edge and queue the state expected after it.
  task automatic drive(input logic s, input logic ab, input logic rb,
                       input logic [5:0] ba, input logic [5:0] ro, input exp_t e);
    @(negedge clk);
    #1;
    stall = s; abs_branch = ab; rel_branch = rb; branch_addr = ba; rel_offset = ro;
    sb.push_back(e);
  endtask

  task automatic seq(input exp_t e);
    drive(1'b0, 1'b0, 1'b0, 6'h00, 6'h00, e);
  endtask

  // Monitor: every negedge with a pending expectation compares the post-edge state.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk_state("edge", e);
      end
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; abs_branch = 1'b0; rel_branch = 1'b0;
    branch_addr = '0; rel_offset = '0;
    #12;
    chk_state("reset", mk(6'd0, 17'd0, 6'd0, 1'b0, 1'b0, 16'd0));
    @(posedge clk); #1 reset = 1'b0;

    // Free-running fetch
    seq(mk(6'd1, 17'd0, 6'd0, 1'b1, 1'b0, 16'd1));
    seq(mk(6'd2, 17'd1, 6'd1, 1'b1, 1'b0, 16'd2));
    seq(mk(6'd3, 17'd2, 6'd2, 1'b1, 1'b0, 16'd3));
    seq(mk(6'd4, 17'd3, 6'd3, 1'b1, 1'b0, 16'd4));

    // Absolute branch to 0x10, then bubble that tries to branch (ignored)
    drive(1'b0, 1'b1, 1'b0, 6'h10, 6'h00, mk(6'h10, 17'd0, 6'd3, 1'b0, 1'b0, 16'd4));
    drive(1'b0, 1'b1, 1'b0, 6'h20, 6'h00, mk(6'h11, 17'h10, 6'h10, 1'b1, 1'b0, 16'd5));
    seq(mk(6'h12, 17'h11, 6'h11, 1'b1, 1'b0, 16'd6));

    // Get ir_pc=5, then relative branch by -2 to 3
    drive(1'b0, 1'b1, 1'b0, 6'd5, 6'h00, mk(6'd5, 17'd0, 6'h11, 1'b0, 1'b0, 16'd6));
    seq(mk(6'd6, 17'd5, 6'd5, 1'b1, 1'b0, 16'd7));
    drive(1'b0, 1'b0, 1'b1, 6'h00, 6'h3E, mk(6'd3, 17'd0, 6'd5, 1'b0, 1'b0, 16'd7));
    seq(mk(6'd4, 17'd3, 6'd3, 1'b1, 1'b0, 16'd8));

    // Both branch kinds: absolute target 9 wins over ir_pc-2
    drive(1'b0, 1'b1, 1'b1, 6'd9, 6'h3E, mk(6'd9, 17'd0, 6'd3, 1'b0, 1'b0, 16'd8));
    seq(mk(6'd10, 17'd9, 6'd9, 1'b1, 1'b0, 16'd9));

    // Stall for 4 edges with a branch pulse in the middle
    drive(1'b1, 1'b0, 1'b0, 6'h00, 6'h00, mk(6'd10, 17'd9, 6'd9, 1'b1, 1'b0, 16'd9));
    drive(1'b1, 1'b1, 1'b0, 6'h20, 6'h00, mk(6'd10, 17'd9, 6'd9, 1'b1, 1'b0, 16'd9));
    drive(1'b1, 1'b0, 1'b1, 6'h20, 6'h05, mk(6'd10, 17'd9, 6'd9, 1'b1, 1'b0, 16'd9));
    drive(1'b1, 1'b0, 1'b0, 6'h00, 6'h00, mk(6'd10, 17'd9, 6'd9, 1'b1, 1'b0, 16'd9));
    seq(mk(6'd11, 17'd10, 6'd10, 1'b1, 1'b0, 16'd10));
    seq(mk(6'd12, 17'd11, 6'd11, 1'b1, 1'b0, 16'd11));

    // Reach ir_pc=7, then branch-to-self halts
    drive(1'b0, 1'b1, 1'b0, 6'd7, 6'h00, mk(6'd7, 17'd0, 6'd11, 1'b0, 1'b0, 16'd11));
    seq(mk(6'd8, 17'd7, 6'd7, 1'b1, 1'b0, 16'd12));
    drive(1'b0, 1'b1, 1'b0, 6'd7, 6'h00, mk(6'd7, 17'd0, 6'd7, 1'b0, 1'b1, 16'd12));
    for (int i = 0; i < 10; i++)
      drive(1'b0, (i % 2) == 0, 1'b0, 6'd3, 6'h00, mk(6'd7, 17'd0, 6'd7, 1'b0, 1'b1, 16'd12));

    // Async reset between edges clears everything before the next posedge
    @(negedge clk); #1;
    reset = 1'b1; abs_branch = 1'b0;
    #2;
    chk_state("async_reset", mk(6'd0, 17'd0, 6'd0, 1'b0, 1'b0, 16'd0));
    @(posedge clk); #1 reset = 1'b0;

    // Top of program space
    seq(mk(6'd1, 17'd0, 6'd0, 1'b1, 1'b0, 16'd1));
    drive(1'b0, 1'b1, 1'b0, 6'd61, 6'h00, mk(6'd61, 17'd0, 6'd0, 1'b0, 1'b0, 16'd1));
    seq(mk(6'd62, 17'd61, 6'd61, 1'b1, 1'b0, 16'd2));
    seq(mk(6'd63, 17'd62, 6'd62, 1'b1, 1'b0, 16'd3));
`ifdef PC_OVF_TRAP_EN
    seq(mk(6'd63, 17'd63, 6'd63, 1'b1, 1'b1, 16'd4));
    seq(mk(6'd63, 17'd63, 6'd63, 1'b1, 1'b1, 16'd4));
`else
    seq(mk(6'd0, 17'd63, 6'd63, 1'b1, 1'b0, 16'd4));
    seq(mk(6'd1, 17'd0, 6'd0, 1'b1, 1'b0, 16'd5));
`endif

    @(negedge clk); #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Program counter and fetch stage for the picoMIPS core; sits directly upstream of the program memory.
- Drives the instruction address to program memory and registers the returned instruction into an instruction register (IR) for decode.
- Handles sequential increment, absolute and relative branches, stalls, branch flush, and halt-on-branch-to-self.
- Keeps a count of instructions fetched.

Parameters:
Psize, 6, address width; program space is 2^Psize words
Isize, 17, instruction width (opcode 3 + rd 3 + rs 3 + imm 8)
Csize, 16, fetch counter width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  hold all state this cycle
abs_branch  input  1  take absolute branch (decoded from ir)
rel_branch  input  1  take relative branch (decoded from ir)
branch_addr  input  Psize  absolute target
rel_offset  input  Psize  two's-complement offset, added to ir_pc
instr  input  Isize  instruction returned by program memory for address
address  output  Psize  PC; drives program memory address
ir  output  Isize  registered instruction
ir_pc  output  Psize  address from which ir was fetched
ir_valid  output  1  ir holds a real instruction, not a bubble
halted  output  1  core halted (branch-to-self)
fetch_count  output  Csize  instructions loaded into ir, saturating

Behaviour:
- Clock and reset: one clock domain. reset is asynchronous and active-high. All state is in registers clocked on posedge clk and cleared on posedge reset.
- Reset values: address=0, ir=0, ir_pc=0, ir_valid=0, halted=0, fetch_count=0.
  - Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.
  - The first fetch occurs on the first edge after reset deasserts.
- Program memory is combinational: instr corresponds to the current address in the same cycle.
- Branch qualification: branch inputs are honoured only when ir_valid=1 (bubbles never branch).
  - take = ir_valid & (abs_branch | rel_branch).
- Target: abs_branch → branch_addr; rel_branch → ir_pc + rel_offset, modulo 2^Psize. If both are asserted, abs_branch wins.
- Per-edge priority, highest first:
  1. halted=1 → hold all state; only reset exits.
  2. stall=1 → hold address, ir, ir_pc, ir_valid, fetch_count; branch inputs are ignored (no pending/latched branch).
  3. take and target==ir_pc → halted←1, address←target, ir_valid←0, ir←0.
  4. take → address←target, ir←0, ir_valid←0 (one-cycle flush of the wrong-path instr), fetch_count unchanged.
  5. Otherwise → ir←instr, ir_pc←address, ir_valid←1, address←address+1, fetch_count←fetch_count+1 (saturates at all-ones).
- Latency:
  - Instruction at address A appears on ir one edge after address=A.
  - A taken branch costs exactly one bubble cycle.
- Wrap: incrementing from 2^Psize-1 goes to 0, unless the optional feature below is compiled in.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro: PC_OVF_TRAP_EN
- Defined: on a sequential increment (case 5) with address == 2^Psize-1, the edge still loads ir←instr, ir_pc←address, ir_valid←1 and increments fetch_count. address holds instead of wrapping, and halted←1 on the same edge.
- Undefined: address wraps to 0 silently.
- Branches to any target are unaffected in both builds.

Test Plan:
- Reset, then 4 free-running edges, with memory model mem[i]=i → address 0→4; ir = 0,1,2,3 on successive edges; ir_valid=1 from edge 1; fetch_count=4.
- abs_branch=1, branch_addr=0x10, ir_valid=1 → next address=0x10, ir_valid=0 for one cycle, then ir=mem[0x10], ir_pc=0x10; fetch_count does not increment on the flush edge.
- ir_pc=5, rel_branch=1, rel_offset=6'h3E (−2) → address=3. Same test with abs_branch also high and branch_addr=9 → address=9.
- stall=1 for 4 edges with abs_branch pulsed during the stall → address, ir, ir_pc, fetch_count unchanged and branch ignored. On stall release, sequential fetch resumes.
- abs_branch with branch_addr == ir_pc=7 → halted=1, address=7, ir_valid=0, held for 10 edges. Async reset mid-cycle → all outputs 0 before the next clk edge.
- Run to address=63 with no branch:
  - Default build → address=0 next, halted=0.
  - PC_OVF_TRAP_EN build → ir=mem[63], address=63, halted=1.
